mmio_timer: RTL and testbench

- Memory-mapped timer peripheral on the CPU data-memory bus; the responder end of the CPU data port, sitting alongside dm.
- Decodes the same ce/we/addr/sel/data signals that dm sees.
- Provides a prescaled 32-bit up-counter with compare, auto-reload and a level interrupt.
- Top level routes data_o to the CPU when hit_o is asserted, otherwise dm output.

---
 rtl/mmio_timer_pkg.sv | 29 ++
 rtl/timer_prescaler.sv | 28 ++
 rtl/mmio_timer.sv | 122 ++++++++++++
 tb/tb_mmio_timer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_timer_pkg.sv
// Shared register map, control bit positions and byte-lane helper
// for the memory-mapped timer peripheral.
package mmio_timer_pkg;

   typedef enum logic [1:0] {
      REG_CTRL  = 2'b00,
      REG_COUNT = 2'b01,
      REG_CMP   = 2'b10,
      REG_STAT  = 2'b11
   } reg_sel_e;

   localparam int TIMER_EN_BIT = 0;
   localparam int TIMER_AR_BIT = 1;
   localparam int TIMER_IE_BIT = 2;

   function automatic logic [31:0] lane_merge(
      input logic [31:0] old_v,
      input logic [31:0] new_v,
      input logic [3:0]  sel
   );
      logic [31:0] r;
      r = old_v;
      for (int i = 0; i < 4; i++) begin
         if (sel[i]) r[8*i +: 8] = new_v[8*i +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Divides clk by PRESCALE while enabled; tick is high for the
// last cycle of each period. Disabling freezes the phase.
module timer_prescaler #(
   parameter int unsigned PRESCALE = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam logic [15:0] LAST = 16'(PRESCALE - 1);

   logic [15:0] r_pcnt;
   logic        w_last;

   assign w_last = (r_pcnt == LAST);
   assign tick   = en & w_last;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pcnt <= '0;
      end else if (en) begin
         r_pcnt <= w_last ? '0 : r_pcnt + 16'd1;
      end
   end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped prescaled 32-bit timer with compare, auto-reload
// and level interrupt, decoded from the CPU data bus.
module mmio_timer
   import mmio_timer_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
   parameter int unsigned PRESCALE  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ce,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [3:0]  sel,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic        hit_o,
   output logic        irq_o
);

   logic [2:0]  r_ctrl;
   logic [31:0] r_count;
   logic [31:0] r_cmp;
   logic        r_match;
   logic        r_irq;

   reg_sel_e    w_reg;
   logic        w_hit;
   logic        w_wr;
   logic        w_rd;
   logic        w_tick;
   logic        w_cmp_eq;
   logic        w_match_set;
   logic        w_w1c;
   logic        w_match_nxt;
   logic [31:0] w_count_tick;
   logic [31:0] w_count_nxt;
   logic [31:0] w_cmp_nxt;
   logic [31:0] w_ctrl_wide;
   logic [2:0]  w_ctrl_nxt;
   logic        w_unused;

   assign w_reg = reg_sel_e'(addr[3:2]);
   assign w_hit = (addr[31:4] == BASE_ADDR[31:4]);
   assign w_wr  = ce & we & w_hit;
   assign w_rd  = ce & ~we & w_hit;
   assign hit_o = w_hit;
   assign irq_o = r_irq;

   assign w_unused = ^{addr[1:0], w_ctrl_wide[31:3]};

   timer_prescaler #(
      .PRESCALE(PRESCALE)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .en   (r_ctrl[TIMER_EN_BIT]),
      .tick (w_tick)
   );

   assign w_cmp_eq    = (r_count == r_cmp);
   assign w_match_set = w_tick & w_cmp_eq;

   always_comb begin
      w_count_tick = r_count;
      if (w_tick) begin
         w_count_tick = (w_cmp_eq && r_ctrl[TIMER_AR_BIT]) ?
                        32'd0 : r_count + 32'd1;
      end
   end

   // Bus writes override only the lanes they touch; the rest keep
   // the tick-updated value so a tick and a write can share a cycle.
   always_comb begin
      w_ctrl_wide = {29'd0, r_ctrl};
      w_count_nxt = w_count_tick;
      w_cmp_nxt   = r_cmp;
      w_w1c       = 1'b0;
      if (w_wr) begin
         unique case (w_reg)
            REG_CTRL:  w_ctrl_wide = lane_merge({29'd0, r_ctrl},
                                                data_i, sel);
            REG_COUNT: w_count_nxt = lane_merge(w_count_tick,
                                                data_i, sel);
            REG_CMP:   w_cmp_nxt   = lane_merge(r_cmp, data_i, sel);
            REG_STAT:  w_w1c       = sel[0] & data_i[0];
         endcase
      end
   end

   assign w_ctrl_nxt  = w_ctrl_wide[2:0];
   assign w_match_nxt = w_match_set | (r_match & ~w_w1c);

   always_comb begin
      data_o = '0;
      if (w_rd) begin
         unique case (w_reg)
            REG_CTRL:  data_o = {29'd0, r_ctrl};
            REG_COUNT: data_o = r_count;
            REG_CMP:   data_o = r_cmp;
            REG_STAT:  data_o = {31'd0, r_match};
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ctrl  <= '0;
         r_count <= '0;
         r_cmp   <= '0;
         r_match <= 1'b0;
         r_irq   <= 1'b0;
      end else begin
         r_ctrl  <= w_ctrl_nxt;
         r_count <= w_count_nxt;
         r_cmp   <= w_cmp_nxt;
         r_match <= w_match_nxt;
         r_irq   <= w_match_nxt & r_ctrl[TIMER_IE_BIT];
      end
   end

endmodule

// File: tb/tb_mmio_timer.sv
// Directed plus random bench for mmio_timer against a cycle-level
// behavioural model of the register file and tick schedule.
module tb_mmio_timer;

   localparam logic [31:0] BASE = 32'h1000_0000;
   localparam int          P    = 4;
   localparam logic [31:0] A_CTRL  = BASE;
   localparam logic [31:0] A_COUNT = BASE + 32'h4;
   localparam logic [31:0] A_CMP   = BASE + 32'h8;
   localparam logic [31:0] A_STAT  = BASE + 32'hC;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ce = 1'b0;
   logic        we = 1'b0;
   logic [31:0] addr = '0;
   logic [3:0]  sel = '0;
   logic [31:0] data_i = '0;
   logic [31:0] data_o;
   logic        hit_o;
   logic        irq_o;

   int n_chk = 0;
   int n_err = 0;

   logic [2:0]  m_ctrl;
   logic [31:0] m_count;
   logic [31:0] m_cmp;
   logic        m_match;
   logic        m_irq;
   int          m_ecnt;

   always #5 clk = ~clk;

   mmio_timer #(
      .BASE_ADDR(BASE),
      .PRESCALE (P)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .ce     (ce),
      .we     (we),
      .addr   (addr),
      .sel    (sel),
      .data_i (data_i),
      .data_o (data_o),
      .hit_o  (hit_o),
      .irq_o  (irq_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_ctrl  = '0;
      m_count = '0;
      m_cmp   = '0;
      m_match = 1'b0;
      m_irq   = 1'b0;
      m_ecnt  = 0;
   endtask

   function automatic logic [31:0] m_read(input logic c, input logic w,
                                          input logic [31:0] a);
      if (!(c && !w && a[31:4] == BASE[31:4])) return 32'd0;
      case (a[3:2])
         2'd0:    return {29'd0, m_ctrl};
         2'd1:    return m_count;
         2'd2:    return m_cmp;
         default: return {31'd0, m_match};
      endcase
   endfunction

   // One bus cycle: check combinational outputs, advance the model,
   // take the clock edge, then check the registered interrupt.
   task automatic bus(input logic c, input logic w, input logic [31:0] a,
                      input logic [3:0] s, input logic [31:0] d,
                      input string tag);
      logic        hit, wr, tick, mt, clr, n_match;
      logic [2:0]  n_ctrl;
      logic [31:0] cnt, n_cmp;
      ce = c; we = w; addr = a; sel = s; data_i = d;
      #1;
      hit = (a[31:4] == BASE[31:4]);
      chk({tag, ":hit"}, {31'd0, hit_o}, {31'd0, hit});
      chk({tag, ":data"}, data_o, m_read(c, w, a));
      wr   = c & w & hit;
      tick = m_ctrl[0] && (m_ecnt % P == P - 1);
      mt   = tick && (m_count == m_cmp);
      cnt  = m_count;
      if (tick) cnt = (mt && m_ctrl[1]) ? 32'd0 : m_count + 32'd1;
      n_ctrl = m_ctrl;
      n_cmp  = m_cmp;
      clr    = 1'b0;
      if (wr) begin
         case (a[3:2])
            2'd0: if (s[0]) n_ctrl = d[2:0];
            2'd1: for (int i = 0; i < 4; i++)
                     if (s[i]) cnt[8*i +: 8] = d[8*i +: 8];
            2'd2: for (int i = 0; i < 4; i++)
                     if (s[i]) n_cmp[8*i +: 8] = d[8*i +: 8];
            default: clr = s[0] & d[0];
         endcase
      end
      n_match = mt | (m_match & ~clr);
      if (m_ctrl[0]) m_ecnt++;
      @(posedge clk);
      m_irq   = n_match & m_ctrl[2];
      m_ctrl  = n_ctrl;
      m_count = cnt;
      m_cmp   = n_cmp;
      m_match = n_match;
      #1;
      chk({tag, ":irq"}, {31'd0, irq_o}, {31'd0, m_irq});
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      bus(1'b1, 1'b1, a, 4'hF, d, "wr");
   endtask

   task automatic rd(input logic [31:0] a);
      bus(1'b1, 1'b0, a, 4'h0, 32'd0, "rd");
   endtask

   initial begin
      logic [31:0] seq[$];
      logic [31:0] a, d;
      m_reset();
      #12 rst = 1'b1;
      @(posedge clk);
      #1;

      rd(A_CTRL);
      rd(A_COUNT);
      rd(A_CMP);
      rd(A_STAT);
      chk("reset_irq", {31'd0, irq_o}, 32'd0);

      wr(A_CMP, 32'd3);
      wr(A_CTRL, 32'h5);
      for (int k = 0; k < 20; k++) rd(k[0] ? A_STAT : A_COUNT);
      rd(A_STAT);
      chk("match_set", data_o, 32'd1);
      chk("irq_up", {31'd0, irq_o}, 32'd1);

      wr(A_CTRL, 32'h0);
      wr(A_STAT, 32'h1);
      wr(A_COUNT, 32'h0);
      wr(A_CMP, 32'd2);
      wr(A_CTRL, 32'h3);
      for (int k = 0; k < 30; k++) begin
         rd(A_COUNT);
         if (seq.size() == 0 || seq[$] != data_o) seq.push_back(data_o);
      end
      chk("ar_len_ok", {31'd0, seq.size() >= 6}, 32'd1);
      for (int k = 0; k < 6 && k < seq.size(); k++)
         chk("ar_seq", seq[k], 32'(k % 3));

      wr(A_CTRL, 32'h0);
      wr(A_COUNT, 32'h0);
      bus(1'b1, 1'b1, A_COUNT, 4'b0101, 32'hAABB_CCDD, "lanes");
      rd(A_COUNT);
      chk("lanes_val", data_o, 32'h00BB_00DD);

      wr(A_STAT, 32'h1);
      wr(A_COUNT, 32'hFFFF_FFFF);
      wr(A_CMP, 32'd5);
      wr(A_CTRL, 32'h1);
      for (int k = 0; k < 6; k++) rd(A_COUNT);
      rd(A_STAT);
      chk("wrap_nomatch", data_o, 32'd0);

      wr(A_CTRL, 32'h4);
      wr(A_COUNT, 32'd10);
      wr(A_CMP, 32'd10);
      wr(A_CTRL, 32'h5);
      for (int k = 0; k < 12 && !m_match; k++) rd(A_STAT);
      rd(A_STAT);
      chk("match_forced", data_o, 32'd1);
      wr(A_CTRL, 32'h4);
      wr(A_COUNT, 32'd20);
      wr(A_CMP, 32'd20);
      wr(A_CTRL, 32'h5);
      for (int k = 0; k < 12; k++) begin
         if (m_ctrl[0] && (m_ecnt % P == P - 1) && m_count == m_cmp)
            break;
         rd(A_STAT);
      end
      bus(1'b1, 1'b1, A_STAT, 4'h1, 32'h1, "w1c_race");
      rd(A_STAT);
      chk("set_wins", data_o, 32'd1);
      rd(A_COUNT);
      chk("post_race_cnt", data_o, 32'd21);

      bus(1'b1, 1'b1, BASE + 32'h10, 4'hF, 32'hFFFF_FFFF, "oow_hi");
      bus(1'b1, 1'b1, 32'h0000_0004, 4'hF, 32'hFFFF_FFFF, "oow_lo");
      bus(1'b1, 1'b0, BASE + 32'h14, 4'hF, 32'd0, "oow_rd");
      rd(A_CTRL);
      rd(A_CMP);

      for (int k = 0; k < 300; k++) begin
         a = ($urandom_range(0, 3) != 0) ? (BASE | 32'($urandom_range(0, 15)))
                                         : $urandom;
         d = $urandom_range(0, 1) ? 32'($urandom_range(0, 8)) : $urandom;
         bus($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), a,
             4'($urandom_range(0, 15)), d, "rand");
      end

      wr(A_CTRL, 32'h0);
      wr(A_STAT, 32'h1);
      wr(A_COUNT, 32'h0);
      wr(A_CMP, 32'd3);
      wr(A_CTRL, 32'h5);
      for (int k = 0; k < 60 && m_count != 32'd7; k++) rd(A_COUNT);
      ce = 1'b1; we = 1'b0; addr = A_COUNT; sel = 4'h0;
      #1;
      chk("pre_rst_cnt", data_o, 32'd7);
      chk("pre_rst_irq", {31'd0, irq_o}, 32'd1);
      #1 rst = 1'b0;
      #1;
      chk("rst_irq", {31'd0, irq_o}, 32'd0);
      for (int k = 0; k < 4; k++) begin
         addr = BASE + 32'(4 * k);
         #1;
         chk("rst_reg", data_o, 32'd0);
      end
      m_reset();
      @(posedge clk);
      #2 rst = 1'b1;
      @(posedge clk);
      #1;
      rd(A_CTRL);
      rd(A_COUNT);
      rd(A_CMP);
      rd(A_STAT);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
